loop_sequencer: RTL and testbench

LOOP_SEQUENCER -- requirements
Module: loop_sequencer

---
 rtl/loop_seq_pkg.sv | 12 +
 rtl/iter_counter.sv | 41 ++++
 rtl/loop_sequencer.sv | 94 +++++++++
 tb/tb_loop_sequencer.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/loop_seq_pkg.sv
// Shared types and defaults for the loop sequencer.
package loop_seq_pkg;

  localparam int unsigned DefaultCntW = 8;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDone
  } loop_state_e;

endpackage

// File: rtl/iter_counter.sv
// Enable/clear modulus counter: counts 0..term_i, wraps to 0 after term_i, flags terminal count.
module iter_counter
  import loop_seq_pkg::*;
#(
  parameter int unsigned Width = DefaultCntW
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             en_i,
  input  logic             clr_i,
  input  logic [Width-1:0] term_i,
  output logic [Width-1:0] count_o,
  output logic             tc_o
);

  localparam logic [Width-1:0] One = Width'(1);

  logic [Width-1:0] count_d, count_q;

  assign tc_o    = (count_q == term_i);
  assign count_o = count_q;

  // Clear has priority so an abort coinciding with a step still lands on zero.
  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = '0;
    end else if (en_i) begin
      count_d = tc_o ? '0 : count_q + One;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/loop_sequencer.sv
// Loop sequencer: offers indices 0..limit to a valid/ready consumer, then pulses done.
// Optional LOOP_SEQ_AUTO_RESTART_EN lets a start during DONE chain straight into a new loop.
module loop_sequencer
  import loop_seq_pkg::*;
#(
  parameter int unsigned CNT_W = DefaultCntW
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [CNT_W-1:0] limit,
  input  logic             abort,
  output logic             iter_valid,
  input  logic             iter_ready,
  output logic [CNT_W-1:0] iter_index,
  output logic             busy,
  output logic             done
);

  loop_state_e      state_d, state_q;
  logic [CNT_W-1:0] limit_d, limit_q;
  logic             cnt_en, cnt_clr, cnt_tc;

  iter_counter #(
    .Width(CNT_W)
  ) u_iter_counter (
    .clk_i  (clk),
    .rst_ni (reset_n),
    .en_i   (cnt_en),
    .clr_i  (cnt_clr),
    .term_i (limit_q),
    .count_o(iter_index),
    .tc_o   (cnt_tc)
  );

  always_comb begin
    state_d    = state_q;
    limit_d    = limit_q;
    cnt_en     = 1'b0;
    cnt_clr    = 1'b0;
    iter_valid = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start && !abort) begin
          limit_d = limit;
          cnt_clr = 1'b1;
          state_d = StRun;
        end
      end
      StRun: begin
        iter_valid = 1'b1;
        busy       = 1'b1;
        if (abort) begin
          cnt_clr = 1'b1;
          state_d = StIdle;
        end else if (iter_ready) begin
          cnt_en = 1'b1;
          if (cnt_tc) begin
            state_d = StDone;
          end
        end
      end
      StDone: begin
        busy    = 1'b1;
        // Abort in DONE suppresses the pulse it would otherwise produce.
        done    = !abort;
        state_d = StIdle;
`ifdef LOOP_SEQ_AUTO_RESTART_EN
        if (start && !abort) begin
          limit_d = limit;
          cnt_clr = 1'b1;
          state_d = StRun;
        end
`endif
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= StIdle;
      limit_q <= '0;
    end else begin
      state_q <= state_d;
      limit_q <= limit_d;
    end
  end

endmodule

// File: tb/tb_loop_sequencer.sv
// Bench for loop_sequencer: transfer-count reference model, directed scenarios, random traffic.
module tb_loop_sequencer;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic       iter_ready = 1'b0;
  logic [7:0] limit = 8'd0;
  logic       iter_valid, busy, done;
  logic [7:0] iter_index;

  always #5 clk = ~clk;

  loop_sequencer #(
    .CNT_W(8)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .start     (start),
    .limit     (limit),
    .abort     (abort),
    .iter_valid(iter_valid),
    .iter_ready(iter_ready),
    .iter_index(iter_index),
    .busy      (busy),
    .done      (done)
  );

  int vectors = 0;
  int miscompares = 0;
  int n_xfer = 0;
  int n_done = 0;
  int xfer_idx[$];

  // Model: transfers still owed in this loop, the loop's limit, and a pending done pulse.
  int m_rem = 0;
  int m_lim = 0;
  bit m_done = 1'b0;
  int exp_idx;
  bit exp_valid, exp_busy, exp_done;

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endfunction

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_rem  <= 0;
      m_lim  <= 0;
      m_done <= 1'b0;
    end else if (m_rem > 0) begin
      if (abort) begin
        m_rem <= 0;
      end else if (iter_ready) begin
        m_rem  <= m_rem - 1;
        m_done <= (m_rem == 1);
      end
    end else if (m_done) begin
      m_done <= 1'b0;
`ifdef LOOP_SEQ_AUTO_RESTART_EN
      if (start && !abort) begin
        m_lim <= int'(limit);
        m_rem <= int'(limit) + 1;
      end
`endif
    end else if (start && !abort) begin
      m_lim <= int'(limit);
      m_rem <= int'(limit) + 1;
    end
  end

  always @(negedge clk) begin
    exp_valid = (m_rem > 0);
    exp_idx   = exp_valid ? (m_lim + 1 - m_rem) : 0;
    exp_done  = m_done && !abort;
    exp_busy  = (m_rem > 0) || m_done;
    check("iter_valid", 32'(iter_valid), 32'(exp_valid));
    check("iter_index", 32'(iter_index), 32'(exp_idx));
    check("busy", 32'(busy), 32'(exp_busy));
    check("done", 32'(done), 32'(exp_done));
    if (iter_valid && iter_ready) begin
      n_xfer++;
      xfer_idx.push_back(int'(iter_index));
    end
    if (done) n_done++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input int lim);
    limit = 8'(lim);
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_idle(input int budget, input string name);
    for (int i = 0; i < budget && busy; i++) tick();
    check(name, 32'(busy), 32'd0);
  endtask

  task automatic wait_index(input int idx, input string name);
    for (int i = 0; i < 50 && !(iter_valid && int'(iter_index) == idx); i++) tick();
    check(name, 32'(iter_index), 32'(idx));
  endtask

  int bx, bd, qs;
  bit [4:0] bp_pat;

  initial begin
    // Reset state.
    tick();
    check("reset_valid", 32'(iter_valid), 32'd0);
    check("reset_index", 32'(iter_index), 32'd0);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_done", 32'(done), 32'd0);
    reset_n = 1'b1;
    tick();

    // Basic loop, limit 3.
    iter_ready = 1'b1;
    bx = n_xfer; bd = n_done; qs = xfer_idx.size();
    do_start(3);
    check("basic_first_valid", 32'(iter_valid), 32'd1);
    check("basic_first_index", 32'(iter_index), 32'd0);
    wait_idle(20, "basic_idle");
    check("basic_xfers", 32'(n_xfer - bx), 32'd4);
    check("basic_dones", 32'(n_done - bd), 32'd1);
    for (int i = 0; i < 4; i++) check("basic_seq", 32'(xfer_idx[qs + i]), 32'(i));

    // Backpressure, limit 2, ready 1,0,0,1,1.
    bx = n_xfer; bd = n_done; qs = xfer_idx.size();
    iter_ready = 1'b0;
    do_start(2);
    bp_pat = 5'b11001;
    for (int i = 0; i < 5; i++) begin
      iter_ready = bp_pat[i];
      tick();
    end
    iter_ready = 1'b1;
    wait_idle(20, "bp_idle");
    check("bp_xfers", 32'(n_xfer - bx), 32'd3);
    check("bp_dones", 32'(n_done - bd), 32'd1);
    for (int i = 0; i < 3; i++) check("bp_seq", 32'(xfer_idx[qs + i]), 32'(i));

    // Edge limits.
    bx = n_xfer; bd = n_done;
    do_start(0);
    wait_idle(10, "lim0_idle");
    check("lim0_xfers", 32'(n_xfer - bx), 32'd1);
    check("lim0_dones", 32'(n_done - bd), 32'd1);
    bx = n_xfer; bd = n_done;
    do_start(255);
    wait_idle(300, "lim255_idle");
    check("lim255_xfers", 32'(n_xfer - bx), 32'd256);
    check("lim255_dones", 32'(n_done - bd), 32'd1);

    // Abort at index 5 of limit 9; transfer of index 5 is consumed.
    bx = n_xfer; bd = n_done;
    do_start(9);
    wait_index(5, "abort_reach");
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("abort_valid", 32'(iter_valid), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    repeat (3) tick();
    check("abort_xfers", 32'(n_xfer - bx), 32'd6);
    check("abort_dones", 32'(n_done - bd), 32'd0);

    // Abort coinciding with the final transfer.
    bx = n_xfer; bd = n_done;
    do_start(2);
    wait_index(2, "abort_last_reach");
    abort = 1'b1;
    tick();
    abort = 1'b0;
    repeat (3) tick();
    check("abort_last_xfers", 32'(n_xfer - bx), 32'd3);
    check("abort_last_dones", 32'(n_done - bd), 32'd0);

    // Start mid-run with a new limit is ignored.
    bx = n_xfer; bd = n_done;
    do_start(4);
    tick();
    limit = 8'd9;
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_idle(20, "midstart_idle");
    check("midstart_xfers", 32'(n_xfer - bx), 32'd5);
    check("midstart_dones", 32'(n_done - bd), 32'd1);

    // Reset mid-loop, then a clean limit 1 loop.
    bd = n_done;
    do_start(7);
    wait_index(4, "rst_reach");
    reset_n = 1'b0;
    #1;
    check("rst_valid", 32'(iter_valid), 32'd0);
    check("rst_index", 32'(iter_index), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    tick();
    reset_n = 1'b1;
    tick();
    check("rst_dones", 32'(n_done - bd), 32'd0);
    bx = n_xfer; bd = n_done;
    do_start(1);
    wait_idle(10, "rst_after_idle");
    check("rst_after_xfers", 32'(n_xfer - bx), 32'd2);
    check("rst_after_dones", 32'(n_done - bd), 32'd1);

    // Start during DONE.
    bx = n_xfer; bd = n_done;
    do_start(1);
    for (int i = 0; i < 10 && !done; i++) tick();
    check("ar_reach_done", 32'(done), 32'd1);
    limit = 8'd2;
    start = 1'b1;
    tick();
    start = 1'b0;
`ifdef LOOP_SEQ_AUTO_RESTART_EN
    check("ar_valid", 32'(iter_valid), 32'd1);
    check("ar_index", 32'(iter_index), 32'd0);
    wait_idle(20, "ar_idle");
    check("ar_xfers", 32'(n_xfer - bx), 32'd5);
    check("ar_dones", 32'(n_done - bd), 32'd2);
`else
    check("ar_valid", 32'(iter_valid), 32'd0);
    check("ar_busy", 32'(busy), 32'd0);
    check("ar_xfers", 32'(n_xfer - bx), 32'd2);
    check("ar_dones", 32'(n_done - bd), 32'd1);
`endif

    // Random traffic against the model.
    for (int i = 0; i < 4000; i++) begin
      start      = ($urandom_range(0, 3) == 0);
      limit      = ($urandom_range(0, 9) == 0) ? 8'($urandom_range(0, 255))
                                               : 8'($urandom_range(0, 5));
      iter_ready = ($urandom_range(0, 2) != 0);
      abort      = ($urandom_range(0, 40) == 0);
      if ($urandom_range(0, 700) == 0) begin
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
      end else begin
        tick();
      end
    end
    start = 1'b0;
    abort = 1'b0;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
